// File: rtl/scrambler_pipe.sv
// scrambler_pipe: self-synchronous x^POLY_LEN + x^TAP + 1 scrambler/descrambler, LSB first, one output register.
// Define SCR_SEED_LOAD_EN to add seed_load/seed ports that preload the LFSR state.
module scrambler_pipe #(
  parameter int POLY_LEN = 58,
  parameter int TAP = 39,
  parameter int MAX_W = 32,
  parameter int WSEL_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic mode,
  input  logic bypass,
  input  logic [WSEL_W-1:0] width_sel,
  input  logic in_valid,
  output logic in_ready,
  input  logic [MAX_W-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [MAX_W-1:0] out_data,
  output logic synced
`ifdef SCR_SEED_LOAD_EN
  ,
  input  logic seed_load,
  input  logic [POLY_LEN-1:0] seed
`endif
);
  localparam int CNT_W = $clog2(POLY_LEN + MAX_W + 1);
  logic [POLY_LEN-1:0] s_q, s_d, s_chain;
  logic [MAX_W-1:0] out_data_q, out_data_d, proc;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sum, w;
  logic [31:0] w_raw;
  logic out_valid_q, out_valid_d, synced_q, synced_d, mode_last_q, mode_last_d;
  logic accept, f;
  assign w_raw = 32'd8 << width_sel;
  assign w = (w_raw > MAX_W) ? CNT_W'(MAX_W) : CNT_W'(w_raw);
`ifdef SCR_SEED_LOAD_EN
  assign in_ready = ~seed_load & (~out_valid_q | out_ready);
`else
  assign in_ready = ~out_valid_q | out_ready;
`endif
  assign accept = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign synced = synced_q;
  // Bit-serial LFSR unrolled across the active width; bits >= W stay zero.
  always_comb begin
    s_chain = s_q;
    proc = '0;
    f = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (CNT_W'(i) < w) begin
        f = s_chain[TAP-1] ^ s_chain[POLY_LEN-1];
        proc[i] = in_data[i] ^ f;
        s_chain = {s_chain[POLY_LEN-2:0], mode ? in_data[i] : proc[i]};
      end
    end
  end
  always_comb begin
    out_valid_d = accept | (out_valid_q & ~out_ready);
    out_data_d = accept ? (bypass ? in_data : proc) : out_data_q;
    s_d = (accept & ~bypass) ? s_chain : s_q;
    mode_last_d = accept ? mode : mode_last_q;
    cnt_sum = ((mode != mode_last_q) ? '0 : cnt_q) + ((mode & ~bypass) ? w : '0);
    cnt_d = ~accept ? cnt_q : (cnt_sum > CNT_W'(POLY_LEN)) ? CNT_W'(POLY_LEN) : cnt_sum;
`ifdef SCR_SEED_LOAD_EN
    s_d = seed_load ? seed : s_d;
    cnt_d = seed_load ? '0 : cnt_d;
`endif
    synced_d = mode_last_d ? (cnt_d >= CNT_W'(POLY_LEN)) : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      s_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      cnt_q <= '0;
      synced_q <= 1'b0;
      mode_last_q <= 1'b0;
    end else begin
      s_q <= s_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      cnt_q <= cnt_d;
      synced_q <= synced_d;
      mode_last_q <= mode_last_d;
    end
  end
endmodule
